// File: rtl/mem_loader.sv
// Boot loader: decodes framed byte-stream load commands into 16-bit memory writes and releases the core on a run command.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to every load frame.
module mem_loader #(
    parameter logic [7:0] HDR_IMEM = 8'h49,
    parameter logic [7:0] HDR_DMEM = 8'h44,
    parameter logic [7:0] HDR_RUN  = 8'h52
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        im_we,
    output logic        dm_we,
    output logic [7:0]  w_addr,
    output logic [15:0] w_data,
    output logic        core_run,
    output logic        error
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_COUNT, S_LO, S_HI, S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_RUN, S_ERR
    } state_t;

    state_t     state_q, state_d;
    logic       imem_q, imem_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] lo_q, lo_d;
    logic [7:0] hi_q, hi_d;
    logic       acc;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
`endif

    assign in_ready = (state_q != S_WRITE) && (state_q != S_RUN) && (state_q != S_ERR);
    assign acc      = in_valid && in_ready;
    assign im_we    = (state_q == S_WRITE) && imem_q;
    assign dm_we    = (state_q == S_WRITE) && !imem_q;
    assign w_addr   = addr_q;
    assign w_data   = {hi_q, lo_q};
    assign core_run = (state_q == S_RUN);
    assign error    = (state_q == S_ERR);

    always_comb begin
        state_d = state_q;
        imem_d  = imem_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        if (acc && state_q inside {S_ADDR, S_COUNT, S_LO, S_HI})
            csum_d = csum_q ^ in_data;
`endif
        case (state_q)
            S_IDLE: if (acc) begin
                if (in_data == HDR_IMEM || in_data == HDR_DMEM) begin
                    imem_d  = (in_data == HDR_IMEM);
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                    state_d = S_ADDR;
                end else if (in_data == HDR_RUN) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_ADDR:  if (acc) begin addr_d = in_data; state_d = S_COUNT; end
            S_COUNT: if (acc) begin cnt_d  = in_data; state_d = S_LO;    end
            S_LO:    if (acc) begin lo_d   = in_data; state_d = S_HI;    end
            S_HI:    if (acc) begin hi_d   = in_data; state_d = S_WRITE; end
            S_WRITE: begin
                // Count 0 encodes 256 words: it wraps to FF and still ends at 1.
                addr_d = addr_q + 8'd1;
                cnt_d  = cnt_q - 8'd1;
                if (cnt_q != 8'd1)
                    state_d = S_LO;
                else
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_IDLE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: if (acc) state_d = (in_data == csum_q) ? S_IDLE : S_ERR;
`endif
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            imem_q  <= 1'b0;
            addr_q  <= 8'h00;
            cnt_q   <= 8'h00;
            lo_q    <= 8'h00;
            hi_q    <= 8'h00;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            imem_q  <= imem_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: byte-level vector table plus framed sequences for wrap, 256-word, stall, error and reset cases.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, im_we, dm_we, core_run, error;
    logic [7:0]  w_addr;
    logic [15:0] w_data;

    int n_cmp = 0;
    int n_err = 0;

    logic        wr_im[$];
    logic [7:0]  wr_addr[$];
    logic [15:0] wr_data[$];

    mem_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .im_we(im_we), .dm_we(dm_we), .w_addr(w_addr), .w_data(w_data),
        .core_run(core_run), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: records every strobe and checks strobe exclusivity and stalled input.
    always @(negedge clk) begin
        if (!rst && (im_we || dm_we)) begin
            wr_im.push_back(im_we);
            wr_addr.push_back(w_addr);
            wr_data.push_back(w_data);
            chk("strobe_onehot", {31'd0, im_we & dm_we}, 32'd0);
            chk("ready_in_write", {31'd0, in_ready}, 32'd0);
        end
    end

    task automatic clear_log();
        wr_im.delete(); wr_addr.delete(); wr_data.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Presents a byte after 'gap' idle cycles; returns at +1 after the accepting edge.
    task automatic send(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_data = b; in_valid = 1'b1; t = 0;
        while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready stuck 0 for byte %0h", b);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [7:0] a, input logic [7:0] n,
                              input logic [15:0] words[$], input int maxgap);
        logic [7:0] cs;
        send(hdr, $urandom_range(maxgap));
        send(a, $urandom_range(maxgap));
        send(n, $urandom_range(maxgap));
        cs = a ^ n;
        foreach (words[i]) begin
            send(words[i][7:0], $urandom_range(maxgap));
            send(words[i][15:8], $urandom_range(maxgap));
            cs = cs ^ words[i][7:0] ^ words[i][15:8];
        end
`ifdef LOADER_CHECKSUM_EN
        send(cs, $urandom_range(maxgap));
`endif
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic chk_writes(input string name, input logic im, input logic [7:0] a0,
                              input logic [15:0] words[$]);
        logic [7:0] a;
        chk({name, "_count"}, wr_addr.size(), words.size());
        a = a0;
        foreach (words[i]) begin
            if (i < wr_addr.size()) begin
                chk({name, "_tgt"},  {31'd0, wr_im[i]}, {31'd0, im});
                chk({name, "_addr"}, {24'd0, wr_addr[i]}, {24'd0, a});
                chk({name, "_data"}, {16'd0, wr_data[i]}, {16'd0, words[i]});
            end
            a = a + 8'd1;
        end
    endtask

    typedef struct {
        logic [7:0]  b;
        logic        im;
        logic        dm;
        logic [7:0]  addr;
        logic [15:0] data;
    } vec_t;

    initial begin
        vec_t tbl[$];
        logic [15:0] wq[$];
        int t;

        // Byte-level table: expected strobes/address/data in the cycle after each byte.
        tbl.push_back('{8'h49, 0, 0, 8'h00, 16'h0000});
        tbl.push_back('{8'h10, 0, 0, 8'h00, 16'h0000});
        tbl.push_back('{8'h02, 0, 0, 8'h00, 16'h0000});
        tbl.push_back('{8'h34, 0, 0, 8'h00, 16'h0000});
        tbl.push_back('{8'h12, 1, 0, 8'h10, 16'h1234});
        tbl.push_back('{8'h78, 0, 0, 8'h00, 16'h0000});
        tbl.push_back('{8'h56, 1, 0, 8'h11, 16'h5678});
`ifdef LOADER_CHECKSUM_EN
        tbl.push_back('{8'h1A, 0, 0, 8'h00, 16'h0000});
`endif
        tbl.push_back('{8'h44, 0, 0, 8'h00, 16'h0000});
        tbl.push_back('{8'hFF, 0, 0, 8'h00, 16'h0000});
        tbl.push_back('{8'h02, 0, 0, 8'h00, 16'h0000});
        tbl.push_back('{8'hAA, 0, 0, 8'h00, 16'h0000});
        tbl.push_back('{8'h00, 0, 1, 8'hFF, 16'h00AA});
        tbl.push_back('{8'hBB, 0, 0, 8'h00, 16'h0000});
        tbl.push_back('{8'h00, 0, 1, 8'h00, 16'h00BB});
`ifdef LOADER_CHECKSUM_EN
        tbl.push_back('{8'hEC, 0, 0, 8'h00, 16'h0000});
`endif

        do_reset();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_im_we",    {31'd0, im_we},    32'd0);
        chk("rst_dm_we",    {31'd0, dm_we},    32'd0);
        chk("rst_w_addr",   {24'd0, w_addr},   32'd0);
        chk("rst_w_data",   {16'd0, w_data},   32'd0);
        chk("rst_core_run", {31'd0, core_run}, 32'd0);
        chk("rst_error",    {31'd0, error},    32'd0);

        clear_log();
        foreach (tbl[i]) begin
            send(tbl[i].b, 0);
            chk("vec_im_we", {31'd0, im_we}, {31'd0, tbl[i].im});
            chk("vec_dm_we", {31'd0, dm_we}, {31'd0, tbl[i].dm});
            chk("vec_ready", {31'd0, in_ready}, {31'd0, !(tbl[i].im || tbl[i].dm)});
            if (tbl[i].im || tbl[i].dm) begin
                chk("vec_addr", {24'd0, w_addr}, {24'd0, tbl[i].addr});
                chk("vec_data", {16'd0, w_data}, {16'd0, tbl[i].data});
            end
        end
        @(posedge clk); #1;
        chk("vec_idle_ready", {31'd0, in_ready}, 32'd1);
        chk("vec_pulses", wr_addr.size(), 32'd4);

        // 256-word data load starting at 00.
        clear_log(); wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back({8'(i) ^ 8'hA5, 8'(i)});
        send_frame(8'h44, 8'h00, 8'h00, wq, 0);
        chk_writes("full256", 1'b0, 8'h00, wq);
        chk("full256_idle", {31'd0, in_ready}, 32'd1);

        // Random valid gaps give identical writes.
        clear_log(); wq.delete();
        wq.push_back(16'h1234); wq.push_back(16'h5678);
        send_frame(8'h49, 8'h10, 8'h02, wq, 3);
        chk_writes("stall", 1'b1, 8'h10, wq);

        // Reset after the LO byte: no strobe, outputs back to reset values, run still works.
        clear_log();
        send(8'h49, 0); send(8'h20, 0); send(8'h01, 0); send(8'h11, 0);
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("midrst_pulses", wr_addr.size(), 32'd0);
        chk("midrst_ready",  {31'd0, in_ready}, 32'd1);
        chk("midrst_addr",   {24'd0, w_addr},   32'd0);
        chk("midrst_data",   {16'd0, w_data},   32'd0);
        chk("midrst_run",    {31'd0, core_run}, 32'd0);
        send(8'h52, 0);
        chk("run_core_run", {31'd0, core_run}, 32'd1);
        chk("run_ready",    {31'd0, in_ready}, 32'd0);
        chk("run_error",    {31'd0, error},    32'd0);
        do_reset();
        chk("run_cleared", {31'd0, core_run}, 32'd0);

        // Bad header: sticky error, later run byte ignored.
        send(8'h7E, 0);
        chk("badhdr_error", {31'd0, error},    32'd1);
        chk("badhdr_ready", {31'd0, in_ready}, 32'd0);
        in_data = 8'h52; in_valid = 1'b1;
        repeat (4) @(posedge clk); #1;
        in_valid = 1'b0;
        chk("badhdr_norun", {31'd0, core_run}, 32'd0);
        chk("badhdr_sticky", {31'd0, error},   32'd1);
        do_reset();
        chk("err_cleared", {31'd0, error}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
        send(8'h49, 0); send(8'h10, 0); send(8'h01, 0); send(8'h34, 0); send(8'h12, 0);
        send(8'h00, 0);
        chk("badcsum_error", {31'd0, error}, 32'd1);
        do_reset();
`endif

        t = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
